multicycle_controller: RTL and testbench

- Main control FSM for the multicycle RV32I core. Sequences the shared datapath (instruction register, register file, ALU, immediate extender, unified memory) over several cycles per instruction.
- Drives the extender's 2-bit immediate-format select. Generates all mux selects and write enables.
- Sits between the instruction register / ALU zero flag and the datapath.
- Supported instructions: lw, sw, R-type ALU (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.

---
 rtl/riscv_ctrl_pkg.sv | 52 +++++
 rtl/alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 167 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and codes for the multicycle RV32I control path.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEMDAT = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  // Map aluop/funct fields onto an ALU control code; unknown funct3 falls back to add.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // only R-type (op5=1) may subtract; addi with bit 30 set stays add
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core.
//
// state      | meaning
// S_FETCH    | read instr at PC, latch IR/OldPC, PC <= PC+4
// S_DECODE   | read regs, ALUOut <= OldPC+imm (branch target), dispatch on op
// S_MEMADR   | ALUOut <= rs1+imm
// S_MEMREAD  | read memory at ALUOut
// S_MEMWB    | rd <= memory data
// S_MEMWRITE | write rs2 to memory at ALUOut
// S_EXECR    | ALUOut <= rs1 op rs2
// S_EXECI    | ALUOut <= rs1 op imm
// S_ALUWB    | rd <= ALUOut
// S_JAL      | PC <= target, ALUOut <= OldPC+4
// S_BEQ      | compare rs1/rs2, PC <= target if equal
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic [2:0] alucontrol,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [1:0] aluop;
  logic [1:0] alusrca_fsm, alusrcb_fsm, resultsrc_fsm;
  logic       adrsrc_fsm, irwrite_fsm, regwrite_fsm, memwrite_fsm, illegal_fsm;
  logic       pcupdate, branch;
  logic [1:0] immsrc_dec;
  logic [2:0] alucontrol_dec;

  // State register, forced back to fetch by async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  // Next-state and per-state control; undefined encodings behave like reset.
  always_comb begin
    state_d       = S_FETCH;
    aluop         = ALUOP_ADD;
    alusrca_fsm   = SRCA_PC;
    alusrcb_fsm   = SRCB_RS2;
    resultsrc_fsm = RES_ALUOUT;
    adrsrc_fsm    = 1'b0;
    irwrite_fsm   = 1'b0;
    regwrite_fsm  = 1'b0;
    memwrite_fsm  = 1'b0;
    illegal_fsm   = 1'b0;
    pcupdate      = 1'b0;
    branch        = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite_fsm   = 1'b1;
        alusrcb_fsm   = SRCB_FOUR;
        resultsrc_fsm = RES_ALU;
        pcupdate      = 1'b1;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        alusrca_fsm = SRCA_OLDPC;
        alusrcb_fsm = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default: begin
            illegal_fsm = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_fsm = SRCA_RS1;
        alusrcb_fsm = SRCB_IMM;
        state_d     = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc_fsm = 1'b1;
        state_d    = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc_fsm = RES_MEMDAT;
        regwrite_fsm  = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc_fsm   = 1'b1;
        memwrite_fsm = 1'b1;
      end
      S_EXECR: begin
        alusrca_fsm = SRCA_RS1;
        aluop       = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alusrca_fsm = SRCA_RS1;
        alusrcb_fsm = SRCB_IMM;
        aluop       = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_fsm = 1'b1;
      end
      S_JAL: begin
        alusrca_fsm = SRCA_OLDPC;
        alusrcb_fsm = SRCB_FOUR;
        pcupdate    = 1'b1;
        state_d     = S_ALUWB;
      end
      S_BEQ: begin
        alusrca_fsm = SRCA_RS1;
        aluop       = ALUOP_SUB;
        branch      = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Immediate format follows the opcode in every state so the extender is always ready.
  always_comb begin
    case (op)
      OP_STORE:  immsrc_dec = IMM_S;
      OP_BRANCH: immsrc_dec = IMM_B;
      OP_JAL:    immsrc_dec = IMM_J;
      default:   immsrc_dec = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (alucontrol_dec)
  );

  // Reset holds every output low even though the state register already reads S_FETCH.
  assign immsrc     = rst_n ? immsrc_dec     : 2'b00;
  assign alusrca    = rst_n ? alusrca_fsm    : 2'b00;
  assign alusrcb    = rst_n ? alusrcb_fsm    : 2'b00;
  assign resultsrc  = rst_n ? resultsrc_fsm  : 2'b00;
  assign adrsrc     = rst_n & adrsrc_fsm;
  assign alucontrol = rst_n ? alucontrol_dec : 3'b000;
  assign irwrite    = rst_n & irwrite_fsm;
  assign pcwrite    = rst_n & (pcupdate | (branch & zero));
  assign regwrite   = rst_n & regwrite_fsm;
  assign memwrite   = rst_n & memwrite_fsm;
  assign illegal    = rst_n & illegal_fsm;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; every cycle compares the full output vector.
module tb_multicycle_controller;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
  logic       adrsrc;
  logic [2:0] alucontrol;
  logic       irwrite, pcwrite, regwrite, memwrite, illegal;
  logic [16:0] obs;

  int errors = 0;
  int checks = 0;

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .immsrc     (immsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .resultsrc  (resultsrc),
    .adrsrc     (adrsrc),
    .alucontrol (alucontrol),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  assign obs = {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
                irwrite, pcwrite, regwrite, memwrite, illegal};

  function automatic logic [16:0] ev(input logic [1:0] imm, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] res,
                                     input logic adr, input logic [2:0] alu,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic mw, input logic ill);
    return {imm, a, b, res, adr, alu, irw, pcw, rw, mw, ill};
  endfunction

  function automatic logic [16:0] e_fetch(input logic [1:0] imm);
    return ev(imm, 2'd0, 2'd2, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_decode(input logic [1:0] imm, input logic ill);
    return ev(imm, 2'd1, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, ill);
  endfunction
  function automatic logic [16:0] e_memadr(input logic [1:0] imm);
    return ev(imm, 2'd2, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_memread(input logic [1:0] imm);
    return ev(imm, 2'd0, 2'd0, 2'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_memwb(input logic [1:0] imm);
    return ev(imm, 2'd0, 2'd0, 2'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_memwrite(input logic [1:0] imm);
    return ev(imm, 2'd0, 2'd0, 2'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [16:0] e_exec(input logic [1:0] imm, input logic [1:0] b,
                                         input logic [2:0] alu);
    return ev(imm, 2'd2, b, 2'd0, 1'b0, alu, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_aluwb(input logic [1:0] imm);
    return ev(imm, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_jal(input logic [1:0] imm);
    return ev(imm, 2'd1, 2'd2, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_beq(input logic [1:0] imm, input logic pcw);
    return ev(imm, 2'd2, 2'd0, 2'd0, 1'b0, 3'b001, 1'b0, pcw, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [16:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Finish the previous instruction, present a new one and check its fetch cycle.
  task automatic start(input string tag, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input logic [1:0] imm);
    cyc();
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    #1;
    chk(tag, e_fetch(imm));
  endtask

  task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [2:0] alu);
    start({tag, " c1"}, o, f3, f7, 1'b1, 2'b00);
    cyc(); chk({tag, " c2"}, e_decode(2'b00, 1'b0));
    cyc(); chk({tag, " c3"}, e_exec(2'b00, (o == RT) ? 2'd0 : 2'd1, alu));
    cyc(); chk({tag, " c4"}, e_aluwb(2'b00));
  endtask

  initial begin
    rst_n = 1'b0; op = JAL; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1;
    @(negedge clk); #1;
    chk("reset", 17'd0);
    @(negedge clk);
    op = LW; zero = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("reset release", e_fetch(2'b00));

    // lw interrupted by reset while in S_MEMREAD
    cyc(); chk("lw-rst c2", e_decode(2'b00, 1'b0));
    cyc(); chk("lw-rst c3", e_memadr(2'b00));
    cyc(); chk("lw-rst c4", e_memread(2'b00));
    rst_n = 1'b0; op = JAL;
    #1;
    chk("mid reset", 17'd0);
    cyc(); chk("mid reset held", 17'd0);
    op = LW; rst_n = 1'b1;
    #1;
    chk("mid reset release", e_fetch(2'b00));

    // lw: 5 cycles
    cyc(); chk("lw c2", e_decode(2'b00, 1'b0));
    cyc(); chk("lw c3", e_memadr(2'b00));
    cyc(); chk("lw c4", e_memread(2'b00));
    cyc(); chk("lw c5", e_memwb(2'b00));

    // sw: 4 cycles
    start("sw c1", SW, 3'b010, 1'b0, 1'b0, 2'b01);
    cyc(); chk("sw c2", e_decode(2'b01, 1'b0));
    cyc(); chk("sw c3", e_memadr(2'b01));
    cyc(); chk("sw c4", e_memwrite(2'b01));

    // beq taken and not taken: 3 cycles each
    start("beq z1 c1", BEQ, 3'b000, 1'b0, 1'b1, 2'b10);
    cyc(); chk("beq z1 c2", e_decode(2'b10, 1'b0));
    cyc(); chk("beq z1 c3", e_beq(2'b10, 1'b1));
    start("beq z0 c1", BEQ, 3'b000, 1'b0, 1'b0, 2'b10);
    cyc(); chk("beq z0 c2", e_decode(2'b10, 1'b0));
    cyc(); chk("beq z0 c3", e_beq(2'b10, 1'b0));

    // R/I decode
    run_alu("sub",   RT, 3'b000, 1'b1, 3'b001);
    run_alu("add",   RT, 3'b000, 1'b0, 3'b000);
    run_alu("addi",  IT, 3'b000, 1'b1, 3'b000);
    run_alu("or",    RT, 3'b110, 1'b0, 3'b011);
    run_alu("andi",  IT, 3'b111, 1'b0, 3'b010);
    run_alu("slt",   RT, 3'b010, 1'b0, 3'b101);
    run_alu("slti",  IT, 3'b010, 1'b1, 3'b101);
    run_alu("sll",   RT, 3'b001, 1'b0, 3'b000);

    // jal: 4 cycles, zero held high to show it is ignored outside S_BEQ
    start("jal c1", JAL, 3'b000, 1'b0, 1'b1, 2'b11);
    cyc(); chk("jal c2", e_decode(2'b11, 1'b0));
    cyc(); chk("jal c3", e_jal(2'b11));
    cyc(); chk("jal c4", e_aluwb(2'b11));

    // illegal opcode: 2 cycles, pulse only in decode
    start("ill c1", BAD, 3'b000, 1'b0, 1'b0, 2'b00);
    cyc(); chk("ill c2", e_decode(2'b00, 1'b1));
    cyc(); chk("ill back to fetch", e_fetch(2'b00));
    op = LW;
    cyc(); chk("after ill decode", e_decode(2'b00, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
